// File: rtl/hazard_controller_pkg.sv
// Shared control types for the hazard controller slice.
// Load marker, forward selects and sequencer states.
package ControlTypeDefs;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } HazState;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle.
// Counter outputs exist only with HAZARD_PERF_COUNTERS_EN.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0] iRs1D, iRs2D;
  logic [4:0] iRs1E, iRs2E, iRdE;
  logic [2:0] iResultSrcE;
  logic       iRegWriteEnE;
  logic [4:0] iRdM;
  logic       iRegWriteEnM;
  logic [4:0] iRdW;
  logic       iRegWriteEnW;
  logic       iPCSrcE;
  logic       iMemReqM;
  logic       iMemReadyM;
  logic [1:0] oForwardAE, oForwardBE;
  logic       oStallF, oStallD, oStallE, oStallM;
  logic       oFlushD, oFlushE, oFlushW;
  logic       oMemErr;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] oStallCycles;
  logic [CNT_W-1:0] oFlushCount;
  logic [CNT_W-1:0] oLoadUseCount;

  modport slave (
    input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE,
    input  iResultSrcE, iRegWriteEnE,
    input  iRdM, iRegWriteEnM, iRdW, iRegWriteEnW,
    input  iPCSrcE, iMemReqM, iMemReadyM,
    output oForwardAE, oForwardBE,
    output oStallF, oStallD, oStallE, oStallM,
    output oFlushD, oFlushE, oFlushW, oMemErr,
    output oStallCycles, oFlushCount, oLoadUseCount
  );

  modport master (
    output iRs1D, iRs2D, iRs1E, iRs2E, iRdE,
    output iResultSrcE, iRegWriteEnE,
    output iRdM, iRegWriteEnM, iRdW, iRegWriteEnW,
    output iPCSrcE, iMemReqM, iMemReadyM,
    input  oForwardAE, oForwardBE,
    input  oStallF, oStallD, oStallE, oStallM,
    input  oFlushD, oFlushE, oFlushW, oMemErr,
    input  oStallCycles, oFlushCount, oLoadUseCount
  );
`else
  modport slave (
    input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE,
    input  iResultSrcE, iRegWriteEnE,
    input  iRdM, iRegWriteEnM, iRdW, iRegWriteEnW,
    input  iPCSrcE, iMemReqM, iMemReadyM,
    output oForwardAE, oForwardBE,
    output oStallF, oStallD, oStallE, oStallM,
    output oFlushD, oFlushE, oFlushW, oMemErr
  );

  modport master (
    output iRs1D, iRs2D, iRs1E, iRs2E, iRdE,
    output iResultSrcE, iRegWriteEnE,
    output iRdM, iRegWriteEnM, iRdW, iRegWriteEnW,
    output iPCSrcE, iMemReqM, iMemReadyM,
    input  oForwardAE, oForwardBE,
    input  oStallF, oStallD, oStallE, oStallM,
    input  oFlushD, oFlushE, oFlushW, oMemErr
  );
`endif
endinterface

// File: rtl/hazard_controller_forward_unit.sv
// E-stage operand forward select for one source register.
// M result beats W result; x0 is never forwarded.
module forward_unit
  import ControlTypeDefs::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output fwd_e       fwd
);

  logic hit_m, hit_w;

  assign hit_m = we_m && (rd_m != 5'd0) && (rd_m == rs);
  assign hit_w = we_w && (rd_w != 5'd0) && (rd_w == rs);

  always_comb begin
    fwd = FWD_REG;
    if (hit_m)
      fwd = FWD_M;
    else if (hit_w)
      fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard/stall sequencer: forwarding, load-use, branch flush, mem wait.
// Optional perf counters: define HAZARD_PERF_COUNTERS_EN.
module hazard_controller
  import ControlTypeDefs::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic           iClk,
  input logic           iRst,
  hazard_controller_if.slave hif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("hazard_controller: bad parameters");
  end

  HazState       state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_err_q;

  fwd_e fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rs   (hif.iRs1E),
    .rd_m (hif.iRdM),
    .we_m (hif.iRegWriteEnM),
    .rd_w (hif.iRdW),
    .we_w (hif.iRegWriteEnW),
    .fwd  (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs   (hif.iRs2E),
    .rd_m (hif.iRdM),
    .we_m (hif.iRegWriteEnM),
    .rd_w (hif.iRdW),
    .we_w (hif.iRegWriteEnW),
    .fwd  (fwd_b)
  );

  logic in_wait, miss, hold, tmo, lu;

  assign in_wait = (state_q == MEM_WAIT);
  assign miss = !in_wait && hif.iMemReqM
             && !hif.iMemReadyM;
  // Timeout cycle releases like ready, so M moves on
  assign hold = in_wait && !hif.iMemReadyM
             && (cnt_q != TMO);
  assign tmo  = in_wait && !hif.iMemReadyM
             && (cnt_q == TMO);
  assign lu   = (hif.iResultSrcE == RESULT_SRC_LOAD)
             && hif.iRegWriteEnE
             && (hif.iRdE != 5'd0)
             && ((hif.iRdE == hif.iRs1D)
              || (hif.iRdE == hif.iRs2D));

  logic [3:0] stall;
  logic [2:0] flush;

  always_comb begin
    stall = 4'b0000;
    flush = 3'b000;
    if (iRst) begin
      flush = 3'b111;
    end else if (miss || hold) begin
      stall = 4'b1111;
      flush = 3'b001;
    end else if (hif.iPCSrcE) begin
      flush = 3'b110;
    end else if (lu) begin
      stall = 4'b1100;
      flush = 3'b010;
    end
  end

  assign {hif.oStallF, hif.oStallD,
          hif.oStallE, hif.oStallM} = stall;
  assign {hif.oFlushD, hif.oFlushE,
          hif.oFlushW} = flush;
  assign hif.oForwardAE = iRst ? FWD_REG : fwd_a;
  assign hif.oForwardBE = iRst ? FWD_REG : fwd_b;
  assign hif.oMemErr = mem_err_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (miss) begin
            state_q <= MEM_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (hif.iMemReadyM) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (tmo) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q, lu_cnt_q;
  logic br_flush, lu_stall;

  // FlushD only comes from a branch outside reset
  assign br_flush = hif.oFlushD && !iRst;
  assign lu_stall = hif.oStallF && !hif.oStallM;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (hif.oStallF)
        stall_cyc_q <= stall_cyc_q + CNT_W'(1);
      if (br_flush)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (lu_stall)
        lu_cnt_q <= lu_cnt_q + CNT_W'(1);
    end
  end

  assign hif.oStallCycles  = stall_cyc_q;
  assign hif.oFlushCount   = flush_cnt_q;
  assign hif.oLoadUseCount = lu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT = 4).
// Checks counters too when HAZARD_PERF_COUNTERS_EN is defined.
module tb_hazard_controller;
  import ControlTypeDefs::*;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int checks = 0;
  int failures = 0;

  hazard_controller_if #(.CNT_W(32)) hif ();

  hazard_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .hif  (hif)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic clr();
    hif.iRs1D = 0; hif.iRs2D = 0;
    hif.iRs1E = 0; hif.iRs2E = 0; hif.iRdE = 0;
    hif.iResultSrcE = 0; hif.iRegWriteEnE = 0;
    hif.iRdM = 0; hif.iRegWriteEnM = 0;
    hif.iRdW = 0; hif.iRegWriteEnW = 0;
    hif.iPCSrcE = 0;
    hif.iMemReqM = 0; hif.iMemReadyM = 0;
  endtask

  function automatic logic [3:0] stl();
    return {hif.oStallF, hif.oStallD,
            hif.oStallE, hif.oStallM};
  endfunction

  function automatic logic [2:0] fl();
    return {hif.oFlushD, hif.oFlushE, hif.oFlushW};
  endfunction

  task automatic chk_ctl(input string tag,
                         input logic [3:0] s,
                         input logic [2:0] f);
    check({tag, "_stall"}, 32'(stl()), 32'(s));
    check({tag, "_flush"}, 32'(fl()), 32'(f));
  endtask

  task automatic set_lu();
    hif.iResultSrcE = 3'b001;
    hif.iRegWriteEnE = 1;
    hif.iRdE = 7;
    hif.iRs2D = 7;
  endtask

  initial begin
    clr();
    step();
    // reset cycle with tempting inputs
    hif.iRdM = 5; hif.iRegWriteEnM = 1;
    hif.iRs1E = 5; hif.iPCSrcE = 1;
    #2;
    chk_ctl("rst", 4'b0000, 3'b111);
    check("rst_fwdA", 32'(hif.oForwardAE), 32'(2'b00));
    check("rst_err", 32'(hif.oMemErr), 0);
    check("rst_state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_PERF_COUNTERS_EN
    check("rst_pc_st", hif.oStallCycles, 0);
    check("rst_pc_fl", hif.oFlushCount, 0);
    check("rst_pc_lu", hif.oLoadUseCount, 0);
`endif
    step();
    iRst = 0;
    clr();

    hif.iRdM = 5; hif.iRegWriteEnM = 1;
    hif.iRdW = 5; hif.iRegWriteEnW = 1;
    hif.iRs1E = 5; hif.iRs2E = 5;
    #2;
    check("fwdA_M", 32'(hif.oForwardAE), 32'(2'b10));
    check("fwdB_M", 32'(hif.oForwardBE), 32'(2'b10));
    chk_ctl("fwd", 4'b0000, 3'b000);
    hif.iRdM = 0;
    #1;
    check("fwdA_W", 32'(hif.oForwardAE), 32'(2'b01));
    hif.iRs1E = 0; hif.iRdW = 0;
    #1;
    check("fwdA_x0", 32'(hif.oForwardAE), 32'(2'b00));
    hif.iRdM = 3; hif.iRegWriteEnM = 0;
    hif.iRdW = 3; hif.iRs2E = 3;
    #1;
    check("fwdB_Woff", 32'(hif.oForwardBE), 32'(2'b01));
    step();
    clr();

    set_lu();
    #2;
    chk_ctl("lu", 4'b1100, 3'b010);
    step();
    clr();
    #2;
    chk_ctl("lu_after", 4'b0000, 3'b000);
    set_lu();
    hif.iRdE = 0; hif.iRs2D = 0;
    #1;
    chk_ctl("lu_x0", 4'b0000, 3'b000);
    step();
    clr();

    set_lu();
    hif.iPCSrcE = 1;
    #2;
    chk_ctl("br_lu", 4'b0000, 3'b110);
    step();
    clr();

    // 3 cycles waiting with a pending branch, ready on the 4th
    hif.iMemReqM = 1;
    hif.iPCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_ctl($sformatf("wait%0d", i), 4'b1111, 3'b001);
      step();
    end
    hif.iMemReadyM = 1;
    #2;
    chk_ctl("wait_rel", 4'b0000, 3'b110);
    step();
    clr();
    #2;
    check("wait_noerr", 32'(hif.oMemErr), 0);
    step();

    hif.iMemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk_ctl($sformatf("tmo%0d", i), 4'b1111, 3'b001);
      step();
    end
    #2;
    chk_ctl("tmo_rel", 4'b0000, 3'b000);
    check("tmo_err_pre", 32'(hif.oMemErr), 0);
    step();
    clr();
    #2;
    check("tmo_err", 32'(hif.oMemErr), 1);
    check("tmo_state", 32'(dut.state_q), 32'(RUN));
    chk_ctl("tmo_idle", 4'b0000, 3'b000);
    step();
    #2;
    check("tmo_err_off", 32'(hif.oMemErr), 0);
    step();

    // ready lands exactly on the timeout cycle
    hif.iMemReqM = 1;
    for (int i = 0; i < 4; i++) step();
    hif.iMemReadyM = 1;
    #2;
    chk_ctl("rdy_tmo", 4'b0000, 3'b000);
    step();
    clr();
    #2;
    check("rdy_tmo_err", 32'(hif.oMemErr), 0);
    step();

    hif.iMemReqM = 1;
    hif.iPCSrcE = 1;
    step();
    step();
    #2;
    chk_ctl("mid_wait", 4'b1111, 3'b001);
    iRst = 1;
    #1;
    chk_ctl("mid_rst", 4'b0000, 3'b111);
    step();
    iRst = 0;
    clr();
    #2;
    check("mid_state", 32'(dut.state_q), 32'(RUN));
    check("mid_err", 32'(hif.oMemErr), 0);
    chk_ctl("mid_after", 4'b0000, 3'b000);
`ifdef HAZARD_PERF_COUNTERS_EN
    check("mid_pc_st", hif.oStallCycles, 0);
    check("mid_pc_fl", hif.oFlushCount, 0);
    check("mid_pc_lu", hif.oLoadUseCount, 0);
    set_lu();
    step();
    clr();
    hif.iPCSrcE = 1;
    step();
    clr();
    #2;
    check("pc_st", hif.oStallCycles, 1);
    check("pc_fl", hif.oFlushCount, 1);
    check("pc_lu", hif.oLoadUseCount, 1);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
